core_bus_arbiter: RTL and testbench

CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

---
 rtl/core_bus_pkg.sv | 14 +
 rtl/core_bus_arbiter.sv | 110 +++++++++++
 tb/tb_core_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_pkg.sv
// Shared arbiter types: ownership states and master indices.
// Pure declarations; no timing or flow-control behaviour.
package core_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } bus_state_e;

  localparam int M_CORE = 0;
  localparam int M_CTRL = 1;

endpackage

// File: rtl/core_bus_arbiter.sv
// Two-master Wishbone-style arbiter with locked bursts and a per-transfer stall timeout.
// One-cycle grant latency; request/ack path is combinational; the non-owner is held off until granted.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              m_cyc_i,
  input  logic [1:0]              m_stb_i,
  input  logic [1:0]              m_we_i,
  input  logic [2*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [2*DATA_WIDTH-1:0] m_data_i,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic [1:0]              m_ack_o,
  output logic [1:0]              m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack_i,
  output logic [1:0]              grant_o
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CW_RAW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW         = (CW_RAW > 0) ? CW_RAW : 1;
  localparam int CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CNT_LAST_I[CW-1:0];
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  bus_state_e    state;
  logic          last_grant;
  logic [CW-1:0] cnt;

  logic owned;
  logic owner;
  logic sel_cyc;
  logic sel_stb;
  logic timeout;

  always_comb begin
    owned   = (state != ST_IDLE);
    owner   = (state == ST_OWN1);
    sel_cyc = m_cyc_i[owner];
    sel_stb = m_stb_i[owner];
    // Ack in the firing cycle wins over the timeout.
    timeout = TO_EN && owned && sel_stb && !s_ack_i && (cnt == CNT_LAST);

    s_cyc_o  = owned && sel_cyc;
    s_stb_o  = owned && sel_stb && !timeout;
    s_we_o   = m_we_i[owner];
    s_addr_o = owner ? m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr_i[ADDR_WIDTH-1:0];
    s_data_o = owner ? m_data_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_data_i[DATA_WIDTH-1:0];
    m_data_o = s_data_i;

    m_ack_o         = 2'b00;
    m_err_o         = 2'b00;
    m_ack_o[M_CORE] = owned && !owner && s_ack_i;
    m_ack_o[M_CTRL] = owned && owner && s_ack_i;
    m_err_o[M_CORE] = timeout && !owner;
    m_err_o[M_CTRL] = timeout && owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      grant_o    <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (m_cyc_i[M_CORE] && (!m_cyc_i[M_CTRL] || last_grant)) begin
            state   <= ST_OWN0;
            grant_o <= 2'b01;
          end else if (m_cyc_i[M_CTRL]) begin
            state   <= ST_OWN1;
            grant_o <= 2'b10;
          end
        end
        ST_OWN0, ST_OWN1: begin
          // Ownership only ends through IDLE, never by handing straight over.
          if (!sel_cyc) begin
            state      <= ST_IDLE;
            grant_o    <= 2'b00;
            last_grant <= owner;
            cnt        <= '0;
          end else if (s_ack_i || timeout) begin
            cnt <= '0;
          end else if (sel_stb) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= 2'b00;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [2*AW-1:0] m_addr_i;
  logic [2*DW-1:0] m_data_i;
  logic [DW-1:0] m_data_o;
  logic [1:0]    m_ack_o, m_err_o, grant_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o, s_data_i;
  logic          s_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc_i  = 2'b00;
    m_stb_i  = 2'b00;
    m_we_i   = 2'b00;
    m_addr_i = '0;
    m_data_i = '0;
    s_data_i = '0;
    s_ack_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    n_tests++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL reset_s_cyc_stb got=%b exp=00", {s_cyc_o, s_stb_o}); end
    n_tests++; if ({m_ack_o, m_err_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_ack_err got=%b exp=0000", {m_ack_o, m_err_o}); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    m_addr_i[AW-1:0] = 32'h0000_0100;
    s_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    n_tests++; if ({grant_o, s_cyc_o} !== 3'b000) begin n_fail++; $display("FAIL single_latency got=%b exp=000", {grant_o, s_cyc_o}); end
    tick();
    s_ack_i = 1'b1;
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL single_grant got=%b exp=01", grant_o); end
    n_tests++; if (s_cyc_o !== 1'b1 || s_addr_o !== 32'h100) begin n_fail++; $display("FAIL single_req got cyc=%b addr=%h exp cyc=1 addr=00000100", s_cyc_o, s_addr_o); end
    n_tests++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL single_ack got=%b exp=01", m_ack_o); end
    n_tests++; if (m_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata got=%h exp=deadbeef", m_data_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    tick();
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL tie_first got=%b exp=01", grant_o); end
    tick();
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
    m_data_i[2*DW-1:DW] = 32'hCAFE_F00D;
    tick();
    tick();
    s_ack_i = 1'b1;
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL tie_second got=%b exp=10", grant_o); end
    n_tests++; if (m_ack_o !== 2'b10) begin n_fail++; $display("FAIL tie_ack_route got=%b exp=10", m_ack_o); end
    n_tests++; if (s_we_o !== 1'b1 || s_data_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL tie_wdata got we=%b data=%h exp we=1 data=cafef00d", s_we_o, s_data_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_burst();
    do_reset();
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    tick();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 1'b1;
      m_addr_i[2*AW-1:AW] = 32'(i * 4);
      @(negedge clk);
      n_tests++; if (m_ack_o !== 2'b10 || grant_o !== 2'b10) begin n_fail++; $display("FAIL burst_ack%0d got ack=%b grant=%b exp ack=10 grant=10", i, m_ack_o, grant_o); end
      tick();
    end
    s_ack_i = 1'b0;
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    tick();
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL burst_release got=%b exp=00", grant_o); end
    tick();
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL burst_handover got=%b exp=01", grant_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    tick();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_tests++;
      if (m_err_o !== ((c == TO) ? 2'b01 : 2'b00) || s_stb_o !== (c != TO)) begin
        n_fail++; $display("FAIL timeout_c%0d got err=%b stb=%b exp err=%b stb=%b", c, m_err_o, s_stb_o, (c == TO) ? 2'b01 : 2'b00, c != TO);
      end
      tick();
    end
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL timeout_keep_grant got=%b exp=01", grant_o); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    tick();
    for (int c = 1; c <= 9; c++) begin
      s_ack_i = (c == TO);
      @(negedge clk);
      n_tests++;
      if (m_err_o !== 2'b00 || m_ack_o !== ((c == TO) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL collide_c%0d got ack=%b err=%b exp ack=%b err=00", c, m_ack_o, m_err_o, (c == TO) ? 2'b01 : 2'b00);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    tick();
    @(negedge clk);
    n_tests++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_owned got=%b exp=1", s_cyc_o); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_drop got cyc=%b grant=%b exp cyc=0 grant=00", s_cyc_o, grant_o); end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_tests++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resume got=%b exp=0", s_cyc_o); end
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    tick();
    @(negedge clk);
    n_tests++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL rstmid_last_grant got=%b exp=01", grant_o); end
    idle_inputs();
    tick();
    tick();
  endtask

  // Reference: owner -1 means idle; stalls counts stalled strobe cycles since the last ack.
  task automatic test_random();
    int mo_owner, mo_last, mo_stalls, x;
    bit owned, stb_x, to;
    logic [1:0] e_grant, e_ack, e_err;
    logic e_cyc, e_stb;
    do_reset();
    mo_owner = -1; mo_last = 1; mo_stalls = 0;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(5) == 0) m_cyc_i[b] = ~m_cyc_i[b];
      m_stb_i  = {($urandom_range(7) != 0), ($urandom_range(7) != 0)};
      m_we_i   = 2'($urandom);
      m_addr_i = {$urandom, $urandom};
      m_data_i = {$urandom, $urandom};
      s_data_i = $urandom;
      s_ack_i  = ($urandom_range(4) == 0);

      owned = (mo_owner >= 0);
      x     = owned ? mo_owner : 0;
      stb_x = owned && m_stb_i[x];
      to    = stb_x && !s_ack_i && (mo_stalls == TO - 1);
      e_grant = owned ? 2'(1 << x) : 2'b00;
      e_cyc   = owned && m_cyc_i[x];
      e_stb   = stb_x && !to;
      e_ack   = (owned && s_ack_i) ? 2'(1 << x) : 2'b00;
      e_err   = to ? 2'(1 << x) : 2'b00;

      @(negedge clk);
      n_tests++;
      if ({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_data_o} !== {e_grant, e_cyc, e_stb, e_ack, e_err, s_data_i}) begin
        n_fail++;
        $display("FAIL rand_ctrl%0d got g=%b cyc=%b stb=%b ack=%b err=%b rd=%h exp g=%b cyc=%b stb=%b ack=%b err=%b rd=%h",
                 n, grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_data_o, e_grant, e_cyc, e_stb, e_ack, e_err, s_data_i);
      end
      if (owned) begin
        n_tests++;
        if ({s_we_o, s_addr_o, s_data_o} !== {m_we_i[x], m_addr_i[x*AW +: AW], m_data_i[x*DW +: DW]}) begin
          n_fail++;
          $display("FAIL rand_path%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h", n, s_we_o, s_addr_o, s_data_o,
                   m_we_i[x], m_addr_i[x*AW +: AW], m_data_i[x*DW +: DW]);
        end
      end
      tick();

      if (!owned) begin
        if (m_cyc_i == 2'b11) mo_owner = 1 - mo_last;
        else if (m_cyc_i[0]) mo_owner = 0;
        else if (m_cyc_i[1]) mo_owner = 1;
        mo_stalls = 0;
      end else if (!m_cyc_i[x]) begin
        mo_last = x; mo_owner = -1; mo_stalls = 0;
      end else if (s_ack_i || to) begin
        mo_stalls = 0;
      end else if (stb_x) begin
        mo_stalls++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
